// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the big-endian byte-enable mapping used by the store path.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  // Bit k of the result enables byte offset k, which lives in bits [31-8k -: 8].
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for stores and lane extraction plus
// sign/zero extension for loads, big-endian byte order.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_wdata,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_unsigned,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_st_size)
      SZ_BYTE: o_st_wdata = {4{i_st_wdata[7:0]}};
      SZ_HALF: o_st_wdata = {2{i_st_wdata[15:0]}};
      default: o_st_wdata = i_st_wdata;
    endcase
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    w_byte = i_ld_rdata[31:24];
      2'd1:    w_byte = i_ld_rdata[23:16];
      2'd2:    w_byte = i_ld_rdata[15:8];
      default: w_byte = i_ld_rdata[7:0];
    endcase
    w_half = i_ld_off[1] ? i_ld_rdata[15:0] : i_ld_rdata[31:16];
  end

  always_comb begin
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_data = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: validates requests, drives the byte-enable
// data memory port and returns aligned, extended load data with a handshake.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [31:0]           resp_badaddr,
  output logic                  mem_en,
  output logic [3:0]            mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  // Window size in bytes; 33 bits so a full 32-bit window cannot wrap.
  localparam logic [32:0] WINDOW = 33'd4 << ADDR_WIDTH;

  lsu_state_e  r_state;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_unsigned;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_badaddr;

  logic [31:0] w_off;
  logic        w_range_err;
  logic        w_align_err;
  logic        w_err;
  logic        w_accept;
  logic        w_issue;
  logic [31:0] w_st_wdata;
  logic [31:0] w_ld_data;

  assign w_off       = req_addr - BASE_ADDR;
  assign w_range_err = (req_addr < BASE_ADDR) || ({1'b0, w_off} >= WINDOW);

  always_comb begin
    case (req_size)
      SZ_BYTE: w_align_err = 1'b0;
      SZ_HALF: w_align_err = req_addr[0];
      SZ_WORD: w_align_err = (req_addr[1:0] != 2'b00);
      default: w_align_err = 1'b1;
    endcase
  end

  assign w_err    = w_range_err | w_align_err;
  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_issue  = w_accept && !w_err;

  lsu_align u_align (
    .i_st_size     (req_size),
    .i_st_wdata    (req_wdata),
    .o_st_wdata    (w_st_wdata),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_ld_off      (r_off),
    .i_ld_rdata    (mem_rdata),
    .o_ld_data     (w_ld_data)
  );

  // Memory port is live only for a qualified access in IDLE; zero otherwise.
  assign mem_en    = w_issue;
  assign mem_write = (w_issue && req_write) ? byte_en(req_size, req_addr[1:0]) : 4'b0000;
  assign mem_addr  = w_issue ? w_off[ADDR_WIDTH+1:2] : '0;
  assign mem_wdata = (w_issue && req_write) ? w_st_wdata : 32'd0;

  assign req_ready    = (r_state == S_IDLE);
  assign resp_valid   = (r_state == S_RESP);
  assign resp_rdata   = r_rdata;
  assign resp_err     = r_err;
  assign resp_badaddr = r_badaddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_size     <= 2'd0;
      r_off      <= 2'd0;
      r_unsigned <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_badaddr  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_err     <= w_err;
            r_badaddr <= w_err ? req_addr : 32'd0;
            r_rdata   <= 32'd0;
            if (w_err || req_write) begin
              r_state <= S_RESP;
            end else begin
              r_state    <= S_LOAD;
              r_size     <= req_size;
              r_unsigned <= req_unsigned;
              r_off      <= req_addr[1:0];
            end
          end
        end
        S_LOAD: begin
          r_rdata <= w_ld_data;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: a byte-array model predicts every cycle's port values,
// and a data memory with registered read sits on the memory port.
module tb_load_store_unit;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_rdata, resp_badaddr;
  logic        resp_err;
  logic        mem_en;
  logic [3:0]  mem_write;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(11), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_badaddr(resp_badaddr),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: big-endian lanes, registered read.
  logic [31:0] dmem [0:2047];
  initial for (int i = 0; i < 2048; i++) dmem[i] = 32'd0;
  always @(posedge clk) begin
    if (mem_en) begin
      for (int k = 0; k < 4; k++)
        if (mem_write[k]) dmem[mem_addr][31-8*k -: 8] <= mem_wdata[31-8*k -: 8];
      mem_rdata <= dmem[mem_addr];
    end
  end

  // Reference model: plain byte array indexed by window offset.
  logic [7:0] mb [0:8191];
  initial for (int i = 0; i < 8192; i++) mb[i] = 8'd0;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic        exp_req_ready, exp_resp_valid, exp_err, exp_mem_en;
  logic [31:0] exp_rdata, exp_bad, exp_mem_wdata;
  logic [3:0]  exp_mem_write;
  logic [10:0] exp_mem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",  32'(req_ready),  32'(exp_req_ready));
      chk("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
      chk("mem_en",     32'(mem_en),     32'(exp_mem_en));
      chk("mem_write",  32'(mem_write),  32'(exp_mem_write));
      chk("mem_addr",   32'(mem_addr),   32'(exp_mem_addr));
      chk("mem_wdata",  mem_wdata,       exp_mem_wdata);
      if (exp_resp_valid) begin
        chk("resp_rdata",   resp_rdata,      exp_rdata);
        chk("resp_err",     32'(resp_err),   32'(exp_err));
        chk("resp_badaddr", resp_badaddr,    exp_bad);
      end
    end
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_err(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (sz == 2'd3) return 1'b1;
    if (a < BASE || off >= 32'd8192) return 1'b1;
    return ((a % 32'(nbytes(sz))) != 32'd0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    logic [31:0] v, off;
    int n;
    n = nbytes(sz);
    off = a - BASE;
    v = 32'd0;
    for (int j = 0; j < n; j++) v = (v << 8) | 32'(mb[off + 32'(j)]);
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] be;
    be = 4'd0;
    for (int j = 0; j < nbytes(sz); j++) be[(int'(a[1:0]) + j) % 4] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (nbytes(sz) == 1) return {4{wd[7:0]}};
    if (nbytes(sz) == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] off;
    int n;
    n = nbytes(sz);
    off = a - BASE;
    for (int j = 0; j < n; j++) mb[off + 32'(j)] = 8'(wd >> (8*(n-1-j)));
  endtask

  task automatic set_quiet_exp(input bit ready, input bit rv);
    exp_req_ready  = ready;
    exp_resp_valid = rv;
    exp_mem_en     = 1'b0;
    exp_mem_write  = 4'd0;
    exp_mem_addr   = 11'd0;
    exp_mem_wdata  = 32'd0;
  endtask

  // While the unit is busy, present a random valid request that must be ignored.
  task automatic drive_junk();
    req_valid    = 1'b1;
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = BASE + 32'($urandom_range(0, 8191));
    req_wdata    = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; resp_ready = 1'b0;
      set_quiet_exp(1'b1, 1'b0);
      chk_en = 1'b1;
    end
  endtask

  task automatic txn(input string nm, input bit w, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     input bit use_lit, input logic [31:0] lit, input logic [3:0] lit_be);
    bit e;
    logic [31:0] rd;
    e = is_err(sz, a);
    rd = (e || w) ? 32'd0 : model_load(sz, uns, a);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; resp_ready = 1'b0;
    exp_req_ready  = 1'b1;
    exp_resp_valid = 1'b0;
    exp_mem_en     = !e;
    exp_mem_addr   = e ? 11'd0 : 11'((a - BASE) >> 2);
    exp_mem_write  = (!e && w) ? model_be(sz, a) : 4'd0;
    exp_mem_wdata  = (!e && w) ? model_wdata(sz, wd) : 32'd0;
    exp_rdata = rd;
    exp_err   = e;
    exp_bad   = e ? a : 32'd0;
    chk_en = 1'b1;
    if (!e && w) model_store(sz, a, wd);
    if (use_lit && w && !e) begin
      @(negedge clk);
      chk({nm, "_be_lit"}, 32'(mem_write), 32'(lit_be));
      chk({nm, "_wd_lit"}, mem_wdata, lit);
    end
    if (!e && !w) begin
      @(posedge clk); #1;
      drive_junk();
      set_quiet_exp(1'b0, 1'b0);
    end
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk); #1;
      drive_junk();
      set_quiet_exp(1'b0, 1'b1);
      resp_ready = (i == hold);
      if (i == 0 && use_lit && !w) begin
        @(negedge clk);
        chk({nm, "_rdata_lit"}, resp_rdata, lit);
        chk({nm, "_model_lit"}, rd, lit);
      end
    end
    $display("txn %-6s write=%0d size=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
             nm, w, sz, a, wd, rd, e);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_resp_valid",   32'(resp_valid), 32'd0);
    chk("rst_resp_err",     32'(resp_err),   32'd0);
    chk("rst_resp_rdata",   resp_rdata,      32'd0);
    chk("rst_resp_badaddr", resp_badaddr,    32'd0);
    chk("rst_req_ready",    32'(req_ready),  32'd1);
    chk("rst_mem_en",       32'(mem_en),     32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(1);

    txn("SW",   1, 2'd2, 0, BASE,     32'h8899_AABB, 0, 1, 32'h8899_AABB, 4'b1111);
    txn("LW",   0, 2'd2, 0, BASE,     32'd0,         0, 1, 32'h8899_AABB, 4'd0);
    txn("LB",   0, 2'd0, 0, BASE + 1, 32'd0,         0, 1, 32'hFFFF_FF99, 4'd0);
    txn("LBU",  0, 2'd0, 1, BASE + 3, 32'd0,         0, 1, 32'h0000_00BB, 4'd0);
    txn("LH",   0, 2'd1, 0, BASE + 2, 32'd0,         0, 1, 32'hFFFF_AABB, 4'd0);
    txn("LHU",  0, 2'd1, 1, BASE,     32'd0,         0, 1, 32'h0000_8899, 4'd0);
    txn("SB",   1, 2'd0, 0, BASE + 2, 32'h0000_0012, 0, 1, 32'h1212_1212, 4'b0100);
    txn("LW",   0, 2'd2, 0, BASE,     32'd0,         0, 1, 32'h8899_12BB, 4'd0);
    idle(2);

    // Error cases: misaligned, out of window on either side, reserved size
    txn("eLW",  0, 2'd2, 0, BASE + 2,       32'd0, 0, 0, 32'd0, 4'd0);
    txn("eSH",  1, 2'd1, 0, BASE + 1,       32'hDEAD_BEEF, 0, 0, 32'd0, 4'd0);
    txn("eLB",  0, 2'd0, 0, 32'h1001_2000,  32'd0, 0, 0, 32'd0, 4'd0);
    txn("eLWlo",0, 2'd2, 0, BASE - 4,       32'd0, 0, 0, 32'd0, 4'd0);
    txn("eSZ3", 0, 2'd3, 0, BASE,           32'd0, 0, 0, 32'd0, 4'd0);

    // Backpressure, then back-to-back next request at the top of the window
    txn("LWh3", 0, 2'd2, 0, BASE,          32'd0,         3, 1, 32'h8899_12BB, 4'd0);
    txn("SHtop",1, 2'd1, 0, BASE + 32'h1FFE, 32'h0000_CAFE, 0, 1, 32'hCAFE_CAFE, 4'b1100);
    txn("LHU",  0, 2'd1, 1, BASE + 32'h1FFE, 32'd0,       0, 1, 32'h0000_CAFE, 4'd0);
    txn("LH",   0, 2'd1, 0, BASE + 32'h1FFE, 32'd0,       2, 1, 32'hFFFF_CAFE, 4'd0);
    txn("SBtop",1, 2'd0, 0, BASE + 32'h1FFF, 32'h0000_0080, 0, 1, 32'h8080_8080, 4'b1000);
    txn("LB",   0, 2'd0, 0, BASE + 32'h1FFF, 32'd0,       0, 1, 32'hFFFF_FF80, 4'd0);

    // Reset asserted while a load is outstanding
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = BASE; req_wdata = 32'd0; resp_ready = 1'b0;
    exp_req_ready = 1'b1; exp_resp_valid = 1'b0; exp_mem_en = 1'b1;
    exp_mem_write = 4'd0; exp_mem_addr = 11'd0; exp_mem_wdata = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    set_quiet_exp(1'b0, 1'b0);
    #2;
    chk("load_busy", 32'(req_ready), 32'd0);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_req_ready",  32'(req_ready),  32'd1);
    chk("arst_resp_rdata", resp_rdata,      32'd0);
    chk("arst_mem_en",     32'(mem_en),     32'd0);
    @(posedge clk); #1;
    chk("arst_hold_valid", 32'(resp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    $display("txn RST    load at %h dropped by reset", BASE);
    idle(2);
    txn("LWpost", 0, 2'd2, 0, BASE, 32'd0, 0, 1, 32'h8899_12BB, 4'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
